branch_history_predictor: RTL

//  Parametrised table of saturating direction counters with an optional global

---
 rtl/branch_history_predictor.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_history_predictor.sv
// Saturating-counter direction predictor with optional gshare history; lookup is combinational,
// updates land on the next clock edge. No backpressure: one resolved branch is accepted every cycle.
module branch_history_predictor #(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         lookup_pc,
    output logic                predict_taken,
    output logic [IDX_BITS-1:0] predict_index,
    input  logic                update_valid,
    input  logic [IDX_BITS-1:0] update_index,
    input  logic                update_taken,
    input  logic                update_mispredict,
    output logic [31:0]         mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    if (CTR_BITS < 2) begin : g_bad_ctr
        $error("branch_history_predictor: CTR_BITS must be at least 2");
    end
    if (GHR_BITS > IDX_BITS || GHR_BITS < 0) begin : g_bad_ghr
        $error("branch_history_predictor: GHR_BITS must lie in 0..IDX_BITS");
    end

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_cur;
    logic [IDX_BITS-1:0] hist_hash;
    logic [IDX_BITS-1:0] pc_idx;
    logic [31:0]         mispredict_count_q;
    logic [31:0]         mispredict_count_d;
    logic                unused_pc_bits;

    assign pc_idx         = lookup_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

    // History advances only when a branch resolves, so fetch always hashes with committed history.
    if (GHR_BITS > 0) begin : g_ghr
        logic [GHR_BITS-1:0] ghr_q;
        logic [GHR_BITS-1:0] ghr_d;

        always_comb begin
            ghr_d = ghr_q;
            if (update_valid) begin
                ghr_d = GHR_BITS'({ghr_q, update_taken});
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ghr_q <= '0;
            end else begin
                ghr_q <= ghr_d;
            end
        end

        assign hist_hash = IDX_BITS'(ghr_q);
    end else begin : g_no_ghr
        assign hist_hash = '0;
    end

    assign predict_index    = pc_idx ^ hist_hash;
    assign predict_taken    = ctr_q[predict_index][CTR_BITS-1];
    assign mispredict_count = mispredict_count_q;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ctr_d[i] = ctr_q[i];
        end
        ctr_cur = ctr_q[update_index];
        if (update_valid) begin
            if (update_taken) begin
                if (ctr_cur != CTR_MAX) begin
                    ctr_d[update_index] = ctr_cur + CTR_BITS'(1);
                end
            end else begin
                if (ctr_cur != '0) begin
                    ctr_d[update_index] = ctr_cur - CTR_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (update_valid && update_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
            mispredict_count_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
